// File: rtl/mult_seq_ctrl_if.sv
// Handshake and shared-adder signals of the sequential multiplier controller.
// The controller connects through the slave modport; the operand source / adder side uses master.
interface mult_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     add_a;
   logic [WIDTH-1:0]     add_b;
   logic [WIDTH-1:0]     add_s;
   logic                 add_cout;

   modport master (
      output start, mcand, mplier, add_s, add_cout,
      input  ready, busy, done, product, add_a, add_b
   );

   modport slave (
      input  start, mcand, mplier, add_s, add_cout,
      output ready, busy, done, product, add_a, add_b
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add unsigned multiplier controller: one WIDTH-bit external adder is reused
// for WIDTH iterations, shifting {carry, sum, Q} right by one each cycle.
module mult_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   mult_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q,   state_d;
   logic [WIDTH-1:0]     acc_q,     acc_d;
   logic [WIDTH-1:0]     q_q,       q_d;
   logic [WIDTH-1:0]     m_q,       m_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_d       = q_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               m_d     = bus.mcand;
               q_d     = bus.mplier;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // The carry-out becomes the new accumulator MSB; dropping it would truncate products.
            acc_d = {bus.add_cout, bus.add_s[WIDTH-1:1]};
            q_d   = {bus.add_s[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               product_d = {bus.add_cout, bus.add_s, q_q[WIDTH-1:1]};
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         q_q       <= '0;
         m_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign bus.ready   = (state_q == IDLE) || (state_q == DONE);
   assign bus.busy    = (state_q == CALC);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;
   assign bus.add_a   = acc_q;
   assign bus.add_b   = q_q[0] ? m_q : '0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl; the bench supplies the external ripple adder.
module tb_mult_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External combinational adder with carry-in tied low.
   assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one multiply and follow it through CALC and DONE into the following cycle.
   task automatic run_mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                           input string tag, output logic [3:0] couts, output logic [3:0] bmask);
      bus.start  = 1'b1;
      bus.mcand  = a;
      bus.mplier = b;
      step();
      bus.start  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"},  bus.busy,  1'b1);
         check({tag, "_ready"}, bus.ready, 1'b0);
         check({tag, "_done"},  bus.done,  1'b0);
         couts[i] = bus.add_cout;
         bmask[i] = |bus.add_b;
         step();
      end
      check({tag, "_done_hi"},  bus.done,    1'b1);
      check({tag, "_product"},  bus.product, exp_p);
      check({tag, "_ready_d"},  bus.ready,   1'b1);
      check({tag, "_busy_d"},   bus.busy,    1'b0);
      step();
      check({tag, "_done_lo"},  bus.done,    1'b0);
      check({tag, "_product_hold"}, bus.product, exp_p);
   endtask

   initial begin
      logic [3:0] couts;
      logic [3:0] bmask;
      int         done_cnt;

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.mcand  = '0;
      bus.mplier = '0;
      #3;
      check("rst_ready",   bus.ready,   1'b1);
      check("rst_busy",    bus.busy,    1'b0);
      check("rst_done",    bus.done,    1'b0);
      check("rst_product", bus.product, 8'h00);
      check("rst_add_a",   bus.add_a,   4'h0);
      check("rst_add_b",   bus.add_b,   4'h0);
      #9 rst_n = 1'b1;
      step();

      // D x B: Q0 sequence 1,1,0,1 across the four iterations.
      run_mult(4'hD, 4'hB, 8'h8F, "db", couts, bmask);
      check("db_bmask", bmask, 4'b1011);

      // F x F: carry-out appears in iterations 2..4.
      run_mult(4'hF, 4'hF, 8'hE1, "ff", couts, bmask);
      check("ff_couts", couts, 4'b1110);

      run_mult(4'h0, 4'h9, 8'h00, "z0", couts, bmask);
      check("z0_bmask", bmask, 4'b0000);
      run_mult(4'h9, 4'h0, 8'h00, "z1", couts, bmask);
      check("z1_bmask", bmask, 4'b0000);

      // 6 x 5 with start re-asserted (other operands) during CALC cycles 2 and 3.
      bus.start  = 1'b1;
      bus.mcand  = 4'h6;
      bus.mplier = 4'h5;
      step();
      bus.start  = 1'b0;
      step();
      bus.start  = 1'b1;
      bus.mcand  = 4'hF;
      bus.mplier = 4'hF;
      step();
      check("ign_busy", bus.busy, 1'b1);
      step();
      bus.start  = 1'b0;
      check("ign_busy2", bus.busy, 1'b1);
      step();
      check("ign_done",    bus.done,    1'b1);
      check("ign_product", bus.product, 8'h1E);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.done) done_cnt++;
      end
      check("ign_single_done", done_cnt, 0);
      check("ign_idle_ready",  bus.ready, 1'b1);

      // Back-to-back: start held across DONE, 3 x 5 then 7 x 2.
      bus.start  = 1'b1;
      bus.mcand  = 4'h3;
      bus.mplier = 4'h5;
      step();
      bus.mcand  = 4'h7;
      bus.mplier = 4'h2;
      step();
      step();
      step();
      step();
      check("b2b_done1",    bus.done,    1'b1);
      check("b2b_product1", bus.product, 8'h0F);
      step();
      bus.start = 1'b0;
      check("b2b_no_idle",   bus.busy,    1'b1);
      check("b2b_prod_hold", bus.product, 8'h0F);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.done) done_cnt++;
      end
      check("b2b_no_early_done", done_cnt, 0);
      step();
      check("b2b_done2",    bus.done,    1'b1);
      check("b2b_product2", bus.product, 8'h0E);
      step();

      // Asynchronous reset between edges during iteration 2.
      bus.start  = 1'b1;
      bus.mcand  = 4'hA;
      bus.mplier = 4'h7;
      step();
      bus.start  = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_product", bus.product, 8'h00);
      check("arst_busy",    bus.busy,    1'b0);
      check("arst_ready",   bus.ready,   1'b1);
      check("arst_done",    bus.done,    1'b0);
      check("arst_add_a",   bus.add_a,   4'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.done) done_cnt++;
      end
      check("arst_no_done", done_cnt, 0);
      run_mult(4'h2, 4'h3, 8'h06, "post", couts, bmask);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
